// File: rtl/alu_resp_checker.sv
// alu_resp_checker
//   Response-side scoreboard for gen_alu benches. The stimulus side pushes
//   expected {s, co} pairs in issue order into a small FIFO. DUT results
//   arrive later with no backpressure, and each one is compared against the
//   FIFO head. Matching and mismatching results are counted, and the index
//   of the first mismatch is captured.
//
// Ports
//   clk, rst           clock (posedge) and synchronous active-high reset
//   start              begin a run (honoured in IDLE or DONE only)
//   num_vectors        number of results to check, latched on start
//   exp_valid/ready    expected-result push handshake
//   exp_s, exp_co      expected result and carry-out
//   dut_valid          DUT result strobe
//   dut_s, dut_co      DUT result and carry-out
//   busy, done         run in progress / run finished
//   pass_cnt           number of matching results
//   fail_cnt           number of mismatching results
//   first_fail_idx     0-based index of the first mismatch
//   first_fail_vld     first_fail_idx holds a real mismatch
//   underflow_err      sticky: a DUT result arrived while the FIFO was empty
module alu_resp_checker #(
  parameter int N     = 4,
  parameter int DEPTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] num_vectors,
  input  logic             exp_valid,
  output logic             exp_ready,
  input  logic [N-1:0]     exp_s,
  input  logic             exp_co,
  input  logic             dut_valid,
  input  logic [N-1:0]     dut_s,
  input  logic             dut_co,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic [CNT_W-1:0] first_fail_idx,
  output logic             first_fail_vld,
  output logic             underflow_err
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] target_q, target_d;
  logic [CNT_W-1:0] pass_cnt_q, pass_cnt_d;
  logic [CNT_W-1:0] fail_cnt_q, fail_cnt_d;
  logic [CNT_W-1:0] first_fail_idx_q, first_fail_idx_d;
  logic             first_fail_vld_q, first_fail_vld_d;
  logic             underflow_err_q, underflow_err_d;
  // One extra pointer bit distinguishes full from empty when the indices match.
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [N:0]       mem_q [DEPTH];

  logic             fifo_empty;
  logic             fifo_full;
  logic             start_acc;
  logic             push;
  logic [N:0]       head;
  logic             match;
  logic [CNT_W:0]   seen_cnt;
  logic             run_complete;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
    return (cnt == {CNT_W{1'b1}}) ? cnt : cnt + 1'b1;
  endfunction

  always_comb begin
    fifo_empty   = (wr_ptr_q == rd_ptr_q);
    fifo_full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    start_acc    = start && (state_q != S_RUN);
    head         = mem_q[rd_ptr_q[AW-1:0]];
    match        = (head == {dut_s, dut_co});
    // Widened sum so saturated counters cannot wrap into a false completion.
    seen_cnt     = {1'b0, pass_cnt_q} + {1'b0, fail_cnt_q};
    run_complete = (seen_cnt == {1'b0, target_q});
  end

  // FSM outputs
  always_comb begin
    busy      = (state_q == S_RUN);
    done      = (state_q == S_DONE);
    // A full FIFO refuses pushes even when a pop happens in the same cycle.
    exp_ready = (state_q == S_RUN) && !fifo_full;
  end

  assign push = exp_valid && exp_ready;

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (run_complete) state_d = S_DONE;
      S_DONE:  if (start) state_d = S_RUN;
      default: state_d = S_IDLE;
    endcase
  end

  // Counters, first-fail capture and FIFO pointers
  always_comb begin
    target_d         = target_q;
    pass_cnt_d       = pass_cnt_q;
    fail_cnt_d       = fail_cnt_q;
    first_fail_idx_d = first_fail_idx_q;
    first_fail_vld_d = first_fail_vld_q;
    underflow_err_d  = underflow_err_q;
    wr_ptr_d         = wr_ptr_q;
    rd_ptr_d         = rd_ptr_q;
    if (start_acc) begin
      target_d         = num_vectors;
      pass_cnt_d       = '0;
      fail_cnt_d       = '0;
      first_fail_idx_d = '0;
      first_fail_vld_d = 1'b0;
      underflow_err_d  = 1'b0;
      wr_ptr_d         = '0;
      rd_ptr_d         = '0;
    end else if (state_q == S_RUN) begin
      if (dut_valid) begin
        if (fifo_empty) begin
          // Result has nothing to compare against: flag it and drop it.
          underflow_err_d = 1'b1;
        end else begin
          rd_ptr_d = rd_ptr_q + 1'b1;
          if (match) begin
            pass_cnt_d = sat_inc(pass_cnt_q);
          end else begin
            fail_cnt_d = sat_inc(fail_cnt_q);
            if (!first_fail_vld_q) begin
              first_fail_idx_d = pass_cnt_q + fail_cnt_q;
              first_fail_vld_d = 1'b1;
            end
          end
        end
      end
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    end
  end

  // Register stage
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= S_IDLE;
      target_q         <= '0;
      pass_cnt_q       <= '0;
      fail_cnt_q       <= '0;
      first_fail_idx_q <= '0;
      first_fail_vld_q <= 1'b0;
      underflow_err_q  <= 1'b0;
      wr_ptr_q         <= '0;
      rd_ptr_q         <= '0;
    end else begin
      state_q          <= state_d;
      target_q         <= target_d;
      pass_cnt_q       <= pass_cnt_d;
      fail_cnt_q       <= fail_cnt_d;
      first_fail_idx_q <= first_fail_idx_d;
      first_fail_vld_q <= first_fail_vld_d;
      underflow_err_q  <= underflow_err_d;
      wr_ptr_q         <= wr_ptr_d;
      rd_ptr_q         <= rd_ptr_d;
    end
  end

  // FIFO storage carries data only, so it is not reset.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= {exp_s, exp_co};
  end

  assign pass_cnt       = pass_cnt_q;
  assign fail_cnt       = fail_cnt_q;
  assign first_fail_idx = first_fail_idx_q;
  assign first_fail_vld = first_fail_vld_q;
  assign underflow_err  = underflow_err_q;

endmodule

// File: tb/tb_alu_resp_checker.sv
module tb_alu_resp_checker;
  localparam int N     = 4;
  localparam int DEPTH = 8;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [CNT_W-1:0] num_vectors = '0;
  logic             exp_valid = 1'b0;
  logic             exp_ready;
  logic [N-1:0]     exp_s = '0;
  logic             exp_co = 1'b0;
  logic             dut_valid = 1'b0;
  logic [N-1:0]     dut_s = '0;
  logic             dut_co = 1'b0;
  logic             busy, done;
  logic [CNT_W-1:0] pass_cnt, fail_cnt, first_fail_idx;
  logic             first_fail_vld, underflow_err;

  int n_cmp = 0;
  int n_err = 0;

  // Transaction-level reference: 0 idle, 1 running, 2 finished.
  int         m_st = 0;
  int         m_target = 0;
  int         m_pass = 0;
  int         m_fail = 0;
  int         m_ffi = 0;
  bit         m_ffv = 0;
  bit         m_uf = 0;
  logic [N:0] m_q[$];

  alu_resp_checker #(.N(N), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .num_vectors(num_vectors),
    .exp_valid(exp_valid), .exp_ready(exp_ready), .exp_s(exp_s), .exp_co(exp_co),
    .dut_valid(dut_valid), .dut_s(dut_s), .dut_co(dut_co),
    .busy(busy), .done(done), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt),
    .first_fail_idx(first_fail_idx), .first_fail_vld(first_fail_vld),
    .underflow_err(underflow_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int sat(input int v);
    return (v >= (1 << CNT_W) - 1) ? v : v + 1;
  endfunction

  // Apply the effect of the current inputs at the coming clock edge.
  task automatic model_step();
    bit fin;
    bit can_push;
    logic [N:0] hd;
    if (rst) begin
      m_st = 0; m_target = 0; m_pass = 0; m_fail = 0;
      m_ffi = 0; m_ffv = 0; m_uf = 0; m_q.delete();
    end else if (m_st != 1) begin
      if (start) begin
        m_st = 1; m_target = int'(num_vectors); m_pass = 0; m_fail = 0;
        m_ffi = 0; m_ffv = 0; m_uf = 0; m_q.delete();
      end
    end else begin
      fin      = (m_pass + m_fail == m_target);
      can_push = exp_valid && (m_q.size() < DEPTH);
      if (dut_valid) begin
        if (m_q.size() == 0) m_uf = 1;
        else begin
          hd = m_q.pop_front();
          if (hd == {dut_s, dut_co}) m_pass = sat(m_pass);
          else begin
            if (!m_ffv) begin
              m_ffi = (m_pass + m_fail) % (1 << CNT_W);
              m_ffv = 1;
            end
            m_fail = sat(m_fail);
          end
        end
      end
      if (can_push) m_q.push_back({exp_s, exp_co});
      if (fin) m_st = 2;
    end
  endtask

  task automatic check_all();
    chk("busy", busy, 32'(m_st == 1));
    chk("done", done, 32'(m_st == 2));
    chk("exp_ready", exp_ready, 32'((m_st == 1) && (m_q.size() < DEPTH)));
    chk("pass_cnt", pass_cnt, m_pass);
    chk("fail_cnt", fail_cnt, m_fail);
    chk("first_fail_vld", first_fail_vld, 32'(m_ffv));
    chk("first_fail_idx", first_fail_idx, m_ffi);
    chk("underflow_err", underflow_err, 32'(m_uf));
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic quiet();
    start = 0; exp_valid = 0; dut_valid = 0;
  endtask

  task automatic do_start(input int nv);
    quiet();
    start = 1; num_vectors = CNT_W'(nv);
    tick();
    start = 0;
  endtask

  task automatic push_one(input logic [N-1:0] s, input logic co);
    exp_valid = 1; exp_s = s; exp_co = co;
    tick();
    exp_valid = 0;
  endtask

  task automatic result_one(input logic [N-1:0] s, input logic co);
    dut_valid = 1; dut_s = s; dut_co = co;
    tick();
    dut_valid = 0;
  endtask

  logic [N-1:0] t2v [5];

  initial begin
    // Reset state
    rst = 1; quiet();
    tick(); tick();
    rst = 0;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ready", exp_ready, 0);
    chk("rst_pass", pass_cnt, 0);
    chk("rst_ffv", first_fail_vld, 0);

    // 1: four matching results
    do_start(4);
    chk("t1_busy", busy, 1);
    for (int i = 0; i < 4; i++) push_one(N'(i * 3), 1'(i));
    tick(); tick();
    for (int i = 0; i < 4; i++) result_one(N'(i * 3), 1'(i));
    tick();
    chk("t1_done", done, 1);
    chk("t1_pass", pass_cnt, 4);
    chk("t1_fail", fail_cnt, 0);
    chk("t1_ffv", first_fail_vld, 0);

    // 2: third of five results differs in the LSB
    t2v[0] = 4'd1; t2v[1] = 4'd2; t2v[2] = 4'b1010; t2v[3] = 4'd3; t2v[4] = 4'd4;
    do_start(5);
    for (int i = 0; i < 5; i++) push_one(t2v[i], 1'b0);
    for (int i = 0; i < 5; i++) result_one((i == 2) ? 4'b1011 : t2v[i], 1'b0);
    tick();
    chk("t2_done", done, 1);
    chk("t2_fail", fail_cnt, 1);
    chk("t2_pass", pass_cnt, 4);
    chk("t2_ffv", first_fail_vld, 1);
    chk("t2_ffi", first_fail_idx, 2);

    // 3: fill to DEPTH, refused push during a pop, then drain in order
    do_start(9);
    for (int i = 0; i < DEPTH; i++) push_one(N'(i + 5), 1'b1);
    chk("t3_full_ready", exp_ready, 0);
    exp_valid = 1; exp_s = 4'd0; exp_co = 1'b0;
    result_one(4'd5, 1'b1);
    exp_valid = 0;
    chk("t3_ready_after_pop", exp_ready, 1);
    chk("t3_pass1", pass_cnt, 1);
    push_one(4'd13, 1'b1);
    for (int i = 6; i <= 13; i++) result_one(N'(i), 1'b1);
    tick();
    chk("t3_done", done, 1);
    chk("t3_pass", pass_cnt, 9);
    chk("t3_fail", fail_cnt, 0);

    // 4: result with empty FIFO, with a same-cycle push
    do_start(3);
    exp_valid = 1; exp_s = 4'd7; exp_co = 1'b0;
    result_one(4'd7, 1'b0);
    exp_valid = 0;
    chk("t4_uf", underflow_err, 1);
    chk("t4_pass0", pass_cnt, 0);
    chk("t4_fail0", fail_cnt, 0);
    tick();
    chk("t4_not_done", done, 0);
    result_one(4'd7, 1'b0);
    chk("t4_pass1", pass_cnt, 1);
    dut_valid = 1;
    start = 1; num_vectors = 16'd1;
    tick();
    quiet();
    chk("t4_start_ignored_uf", underflow_err, 1);
    chk("t4_still_busy", busy, 1);
    rst = 1; tick(); rst = 0;

    // 5: reset in the middle of a run, then a fresh short run
    do_start(6);
    for (int i = 0; i < 3; i++) push_one(N'(i + 9), 1'b0);
    for (int i = 0; i < 3; i++) result_one(N'(i + 9), 1'b0);
    chk("t5_pass3", pass_cnt, 3);
    rst = 1; tick(); rst = 0;
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_pass", pass_cnt, 0);
    chk("t5_rst_ready", exp_ready, 0);
    do_start(2);
    push_one(4'd2, 1'b1); push_one(4'd3, 1'b0);
    result_one(4'd2, 1'b1); result_one(4'd3, 1'b0);
    tick();
    chk("t5_done", done, 1);
    chk("t5_pass", pass_cnt, 2);

    // 6: zero-length run, then two mismatches
    do_start(0);
    chk("t6_busy", busy, 1);
    tick();
    chk("t6_done", done, 1);
    do_start(3);
    for (int i = 0; i < 3; i++) push_one(N'(i + 1), 1'b0);
    result_one(4'd1, 1'b0);
    result_one(4'd15, 1'b0);
    chk("t6_ffi_first", first_fail_idx, 1);
    result_one(4'd14, 1'b1);
    tick();
    chk("t6_ffi_kept", first_fail_idx, 1);
    chk("t6_fail", fail_cnt, 2);
    chk("t6_pass", pass_cnt, 1);
    chk("t6_done", done, 1);

    // Randomized runs against the reference queue
    for (int r = 0; r < 8; r++) begin
      int budget;
      do_start($urandom_range(1, 20));
      budget = 0;
      while (m_st != 2 && budget < 400) begin
        exp_valid = ($urandom % 2) == 0;
        exp_s = N'($urandom); exp_co = 1'($urandom);
        dut_valid = ($urandom % 3) == 0;
        if (m_q.size() > 0 && ($urandom % 5) != 0) {dut_s, dut_co} = m_q[0];
        else begin dut_s = N'($urandom); dut_co = 1'($urandom); end
        start = ($urandom % 40) == 0;
        num_vectors = CNT_W'($urandom_range(0, 5));
        tick();
        budget++;
      end
      quiet();
      chk("rnd_done", done, 1);
      for (int k = 0; k < 3; k++) begin
        dut_valid = 1; dut_s = N'($urandom); dut_co = 1'($urandom);
        tick();
      end
      quiet();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
